// File: rtl/pixel_sink_pkg.sv
// rtl/pixel_sink_pkg.sv - shared screen geometry, state encoding and pixel record for the framebuffer pixel sink
package pixel_sink_pkg;

    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int FB_WORDS  = 76800;
    localparam int FB_ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] colour;
    } pixel_t;

    // y*320 + x built from shifts so no multiplier is inferred
    function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
        logic [FB_ADDR_W-1:0] yw;
        logic [FB_ADDR_W-1:0] xw;
        yw = {{(FB_ADDR_W-8){1'b0}}, y};
        xw = {{(FB_ADDR_W-9){1'b0}}, x};
        return (yw << 8) + (yw << 6) + xw;
    endfunction

endpackage

// File: rtl/pixel_sink_fifo.sv
// rtl/pixel_sink_fifo.sv - small synchronous FIFO buffering accepted on-screen pixels
module pixel_sink_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == ($bits(count))'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_sink_fb.sv
// rtl/pixel_sink_fb.sv - clips, queues and commits sprite pixels to the 320x240 framebuffer, with clear sweep
// Build option: PIXEL_SINK_TRANSPARENT_EN drops pixels whose colour equals TRANSPARENT_COLOUR.
module pixel_sink_fb
    import pixel_sink_pkg::*;
#(
    parameter int         FIFO_DEPTH         = 4,
    parameter logic [2:0] CLEAR_COLOUR       = 3'b000,
    parameter logic [2:0] TRANSPARENT_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [8:0]           pix_x,
    input  logic [7:0]           pix_y,
    input  logic [2:0]           pix_colour,
    input  logic                 clear_req,
    output logic                 clear_done,
    output logic                 busy,
    output logic [7:0]           drop_count,
    output logic                 fb_we,
    input  logic                 fb_ready,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [2:0]           fb_data
);

    localparam logic [8:0]           X_LIMIT   = 9'(SCREEN_W);
    localparam logic [7:0]           Y_LIMIT   = 8'(SCREEN_H);
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_WORDS - 1);

    state_t state;
    pixel_t in_pix;
    pixel_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_pop;
    logic   xfer;
    logic   keep;
    logic   write_done;
    logic   streaming;

    assign in_pix     = '{x: pix_x, y: pix_y, colour: pix_colour};
    assign pix_ready  = (state == IDLE) && !fifo_full;
    assign xfer       = pix_valid && pix_ready;
    assign write_done = fb_we && fb_ready;
    assign streaming  = (state == IDLE) || (state == DRAIN);
    assign busy       = !fifo_empty || fb_we || (state != IDLE);

`ifdef PIXEL_SINK_TRANSPARENT_EN
    assign keep = (pix_x < X_LIMIT) && (pix_y < Y_LIMIT) && (pix_colour != TRANSPARENT_COLOUR);
`else
    logic unused_transparent;
    assign unused_transparent = ^TRANSPARENT_COLOUR;
    assign keep = (pix_x < X_LIMIT) && (pix_y < Y_LIMIT);
`endif

    // Outside the sweep fb_we doubles as the output register's valid bit
    assign fifo_pop = streaming && !fifo_empty && (!fb_we || fb_ready);

    pixel_sink_fifo #(
        .WIDTH ($bits(pixel_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (xfer && keep),
        .push_data (in_pix),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            clear_done <= 1'b0;
            drop_count <= '0;
        end else begin
            clear_done <= 1'b0;
            if (xfer && !keep && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            case (state)
                IDLE, DRAIN: begin
                    if (fifo_pop) begin
                        fb_we   <= 1'b1;
                        fb_addr <= pix_addr(head.x, head.y);
                        fb_data <= head.colour;
                    end else if (write_done) begin
                        fb_we <= 1'b0;
                    end
                    if ((state == IDLE) && clear_req) begin
                        state <= DRAIN;
                    end else if ((state == DRAIN) && fifo_empty && !fb_we) begin
                        state   <= CLEAR;
                        fb_we   <= 1'b1;
                        fb_addr <= '0;
                        fb_data <= CLEAR_COLOUR;
                    end
                end
                CLEAR: begin
                    if (write_done) begin
                        if (fb_addr == LAST_ADDR) begin
                            state      <= DONE;
                            fb_we      <= 1'b0;
                            fb_addr    <= '0;
                            clear_done <= 1'b1;
                        end else begin
                            fb_addr <= fb_addr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_sink_fb.sv
// tb/tb_pixel_sink_fb.sv - randomized self-checking bench for pixel_sink_fb against a queue-based write model
module tb_pixel_sink_fb;

    localparam logic [2:0] CLEAR_COLOUR       = 3'b000;
    localparam logic [2:0] TRANSPARENT_COLOUR = 3'b000;
    localparam int         FB_WORDS           = 76800;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pix_valid = 1'b0;
    logic [8:0]  pix_x = '0;
    logic [7:0]  pix_y = '0;
    logic [2:0]  pix_colour = '0;
    logic        clear_req = 1'b0;
    logic        fb_ready = 1'b1;
    logic        pix_ready;
    logic        clear_done;
    logic        busy;
    logic [7:0]  drop_count;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;

    int          n_tests = 0;
    int          n_fail = 0;
    int          exp_q[$];
    int          exp_drops = 0;
    bit          sweep_active = 0;
    int          sweep_next = 0;
    int          done_cnt = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_word = '0;
    bit          rand_ready = 0;
    int          n_acc;

    pixel_sink_fb dut (
        .clk        (clk),
        .resetn     (resetn),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .clear_req  (clear_req),
        .clear_done (clear_done),
        .busy       (busy),
        .drop_count (drop_count),
        .fb_we      (fb_we),
        .fb_ready   (fb_ready),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic void model_accept(input int x, input int y, input int c);
        bit drop;
        drop = (x >= 320) || (y >= 240);
`ifdef PIXEL_SINK_TRANSPARENT_EN
        if (c == int'(TRANSPARENT_COLOUR)) drop = 1;
`endif
        if (drop) begin
            if (exp_drops < 255) exp_drops++;
        end else begin
            exp_q.push_back(((x + y * 320) * 8) + c);
        end
    endfunction

    // Write monitor: every completed framebuffer write is matched in order against the model
    always @(negedge clk) begin
        logic [31:0] word;
        word = {12'b0, fb_addr, fb_data};
        if (!resetn) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && fb_we) check("stall_hold", word, prev_word);
            if (clear_done) done_cnt++;
            if (fb_we && fb_ready) begin
                if (exp_q.size() > 0) begin
                    check("pix_write", word, exp_q.pop_front());
                end else if (sweep_active) begin
                    check("clear_write", word, (sweep_next * 8) + int'(CLEAR_COLOUR));
                    sweep_next++;
                    if (sweep_next == FB_WORDS) sweep_active = 0;
                end else begin
                    check("stray_write", {31'b0, fb_we}, 32'd0);
                end
            end
            prev_stall = fb_we && !fb_ready;
            prev_word  = word;
        end
    end

    // All tasks start and end 1ns after a rising edge
    task automatic send_pix(input int x, input int y, input int c, input int max_wait, output bit acc);
        pix_valid  = 1'b1;
        pix_x      = 9'(x);
        pix_y      = 8'(y);
        pix_colour = 3'(c);
        acc = 0;
        for (int i = 0; i < max_wait && !acc; i++) begin
            if (rand_ready) fb_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (pix_ready) begin
                acc = 1;
                model_accept(x, y, c);
            end
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
    endtask

    task automatic send_ok(input int x, input int y, input int c);
        bit acc;
        send_pix(x, y, c, 60, acc);
        check("accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fb_we", {31'b0, fb_we}, 32'd0);
        check("rst_fb_addr", {15'b0, fb_addr}, 32'd0);
        check("rst_fb_data", {29'b0, fb_data}, 32'd0);
        check("rst_clear_done", {31'b0, clear_done}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_drop_count", {24'b0, drop_count}, 32'd0);
        check("rst_pix_ready", {31'b0, pix_ready}, 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Single pixel latency
        send_ok(5, 2, 5);
        @(negedge clk);
        @(negedge clk);
        check("single_we", {31'b0, fb_we}, 32'd1);
        check("single_addr", {15'b0, fb_addr}, 32'd645);
        check("single_data", {29'b0, fb_data}, 32'd5);
        @(negedge clk);
        check("single_busy_fall", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // Backpressure: five pixels fit with the framebuffer stalled
        fb_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send_pix(i * 37 + 3, i * 11 + 1, i + 1, 1, acc);
            if (acc) n_acc++;
        end
        check("bp_accepted", n_acc, 32'd5);
        @(negedge clk);
        check("bp_ready_low", {31'b0, pix_ready}, 32'd0);
        @(posedge clk);
        #1;
        fb_ready = 1'b1;
        send_ok(5 * 37 + 3, 5 * 11 + 1, 6);
        wait_idle(100);
        check("bp_all_written", exp_q.size(), 32'd0);

        // Clipping boundaries
        send_ok(320, 0, 4);
        send_ok(0, 240, 4);
        @(negedge clk);
        check("clip_drops", {24'b0, drop_count}, exp_drops);
        @(posedge clk);
        #1;
        send_ok(319, 239, 3);
        wait_idle(100);
        check("clip_corner_done", exp_q.size(), 32'd0);

        // Transparent colour at (10,10)
        send_ok(10, 10, 0);
        wait_idle(100);
        check("transp_drops", {24'b0, drop_count}, exp_drops);
        check("transp_q", exp_q.size(), 32'd0);

        // Randomized stream with random framebuffer stalls
        rand_ready = 1;
        for (int i = 0; i < 60; i++) begin
            send_ok($urandom_range(0, 359), $urandom_range(0, 259), $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                fb_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 0;
        fb_ready = 1'b1;
        wait_idle(200);
        check("rand_all_written", exp_q.size(), 32'd0);
        check("rand_drops", {24'b0, drop_count}, exp_drops);

        // Clear sweep with two pixels queued behind a stall
        fb_ready = 1'b0;
        send_ok(100, 50, 6);
        send_ok(101, 50, 7);
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        sweep_active = 1;
        sweep_next = 0;
        @(negedge clk);
        check("drain_ready_low", {31'b0, pix_ready}, 32'd0);
        @(posedge clk);
        #1;
        fb_ready = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        wait_idle(80000);
        check("clear_count", sweep_next, FB_WORDS);
        check("clear_done_once", done_cnt, 32'd1);
        check("clear_q_empty", exp_q.size(), 32'd0);

        // Reset in the middle of a sweep
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        sweep_active = 1;
        sweep_next = 0;
        for (int i = 0; i < 3000 && sweep_next < 1000; i++) begin
            @(posedge clk);
            #1;
        end
        check("sweep_reached_1000", {31'b0, (sweep_next >= 1000)}, 32'd1);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sweep_active = 0;
        exp_drops = 0;
        check("midrst_fb_we", {31'b0, fb_we}, 32'd0);
        check("midrst_pix_ready", {31'b0, pix_ready}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_drops", {24'b0, drop_count}, exp_drops);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("midrst_no_done", done_cnt, 32'd1);
        check("midrst_idle_we", {31'b0, fb_we}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_sink_fb.md
# pixel_sink_fb

Consumer end of the sprite-plot pixel stream: accepts (x, y, colour) writes from the sprite plotters and commits them to the 320x240, 3-bit framebuffer write port. It computes the linear address, drops off-screen pixels, absorbs framebuffer stalls in a small FIFO, and provides a full-screen clear sweep. It sits between the sprite FSMs and the video memory.

## Interface
- FIFO_DEPTH, 4: pixel FIFO entries; power of two, at least 2.
- CLEAR_COLOUR, 3'b000: colour written by the clear sweep.
- TRANSPARENT_COLOUR, 3'b000: colour dropped when transparency is compiled in.
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- pix_valid  in  1  producer has a pixel.
- pix_ready  out  1  block accepts a pixel this cycle.
- pix_x  in  9  pixel column, 0..319 on screen.
- pix_y  in  8  pixel row, 0..239 on screen.
- pix_colour  in  3  pixel colour.
- clear_req  in  1  single-cycle request to clear the whole screen.
- clear_done  out  1  single-cycle pulse when the clear completes.
- busy  out  1  FIFO or output register holds data, or a drain/clear is in progress.
- drop_count  out  8  off-screen and transparent drops; saturates at 255.
- fb_we  out  1  write request to the framebuffer.
- fb_ready  in  1  framebuffer accepts the write this cycle.
- fb_addr  out  17  linear address, y*320 + x.
- fb_data  out  3  colour to write.

## Operation
- Input handshake: a pixel transfers on an edge where pix_valid && pix_ready.
- pix_ready = (state == IDLE) && !fifo_full. It is combinational and registered inputs only.
- Clip: a transferred pixel with x >= 320 or y >= 240 is consumed but not enqueued, and drop_count increments.
- Address: y*320 + x, computed as (y<<8) + (y<<6) + x, 17 bits. The maximum is 76799.
- Output register: holds one write, with fb_* registered. A write completes on an edge where fb_we && fb_ready.
  - The register reloads from the FIFO head on the same edge a write completes, or whenever it is empty.
  - fb_addr and fb_data stay stable while fb_we is high and fb_ready is low.
- FIFO behaviour:
  - A simultaneous push and pop leaves the count unchanged.
  - There is no push when full, because pix_ready is low.
  - The FIFO never pops into a full output register that is stalled.
- States:
  - IDLE: normal streaming. On clear_req, go to DRAIN.
  - DRAIN: pix_ready is 0. When the FIFO is empty and the output register is empty, go to CLEAR.
  - CLEAR: a 17-bit counter drives fb_addr with fb_data = CLEAR_COLOUR and fb_we = 1. The counter advances on each completed write. The write at address 76799 completing moves to DONE.
  - DONE: clear_done = 1 for one cycle, then return to IDLE.
- clear_req in any state other than IDLE is ignored.
- If clear_req arrives on the same edge a pixel transfers, the pixel is accepted and written before the sweep starts.
- drop_count saturates at 255 and clears only on reset.

## Timing
- Reset values, on the cycle after resetn is sampled low:
  - State is IDLE and the FIFO is empty.
  - fb_we = 0, fb_addr = 0, fb_data = 0, clear_done = 0, busy = 0, drop_count = 0.
  - pix_ready = 1.
- Reset mid-clear or mid-stream aborts immediately. Queued pixels are discarded and the clear counter returns to 0.
- Latency: a pixel transferred at edge k into an empty pipe has fb_we high from edge k+1. With fb_ready held high, throughput is 1 pixel per cycle.
- Clear duration with fb_ready held high: 76800 write cycles, plus 1 DONE cycle, plus the drain time.
- busy falls on the edge where the last queued write completes in IDLE.

## Configuration
- PIXEL_SINK_TRANSPARENT_EN defined: a transferred pixel with colour == TRANSPARENT_COLOUR is consumed, not enqueued, and counted in drop_count. This lets sprite backgrounds pass through without overdrawing.
- Not defined: every on-screen pixel is written regardless of colour. The TRANSPARENT_COLOUR parameter is unused.

## Structure
- Package pixel_sink_pkg holds:
  - SCREEN_W = 320, SCREEN_H = 240, FB_WORDS = 76800, FB_ADDR_W = 17.
  - The state enum (IDLE, DRAIN, CLEAR, DONE).
  - The pixel struct {x[8:0], y[7:0], colour[2:0]}.
- Sub-module pixel_sink_fifo is a synchronous FIFO with width 20, depth FIFO_DEPTH, and push/pop/full/empty outputs. Address computation and the FSM stay in the top level.

## Test plan
- Single pixel: (x=5, y=2, colour=3'b101) with fb_ready=1 produces exactly one write at fb_addr=645 and fb_data=5 one cycle after transfer. busy then falls.
- Stall/backpressure: hold fb_ready=0 and stream 6 pixels. Five are accepted (4 in the FIFO plus 1 in the output register) and pix_ready drops. After fb_ready is released, all 6 are written in order at the correct addresses, and fb_addr stays stable while stalled.
- Clip: pixels (320,0) and (0,240) are consumed with no fb_we and drop_count=2. Pixel (319,239) writes fb_addr=76799.
- Clear: with 2 pixels queued, pulse clear_req. Both pixels are written first, then 76800 writes of CLEAR_COLOUR at 0..76799. clear_done pulses once, and a clear_req during the sweep is ignored.
- Reset mid-clear: assert resetn=0 at sweep address 1000. The next cycle shows fb_we=0 and pix_ready=1, and no clear_done occurs.
- Transparency (macro defined): colour 3'b000 at (10,10) gives no write and drop_count=1. Without the macro, the same pixel writes address 3210.
